// File: rtl/sram_readout.sv
// Read-side controller for the capture SRAM. It streams word_cnt words from base_addr
// upward (wrapping) onto a valid/ready master port, with a small FIFO absorbing read latency.
module sram_readout #(
    parameter int DATA_LEN   = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_LEN   = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                rd_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic [ADDR_LEN:0]   word_cnt,
    output logic                busy,
    output logic                done,
    output logic [ADDR_LEN-1:0] sram_rd_addr,
    output logic                sram_rd_en_n,
    input  logic [DATA_LEN-1:0] sram_data_i,
    output logic [DATA_LEN-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] FIFO_FULL = FIFO_DEPTH[PTR_W+1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state;
    logic [ADDR_LEN-1:0] next_addr;
    logic [ADDR_LEN:0]   total_cnt;
    logic [ADDR_LEN:0]   issued_cnt;
    logic [ADDR_LEN:0]   issued_nxt;

    logic [DATA_LEN-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      fifo_cnt;

    logic                req_vld_p1;
    logic                pop;
    logic                launch;
    logic                last_launch;
    logic                drained;
    logic                cancel;
    logic [PTR_W+1:0]    occ_after;

    // A request launched on the previous edge delivers its word on this edge.
    assign req_vld_p1 = ~sram_rd_en_n;
    assign m_valid    = (fifo_cnt != '0);
    assign m_data     = m_valid ? fifo_mem[rd_ptr] : '0;
    assign pop        = m_valid && m_ready;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign cancel     = abort && (state != S_IDLE);

    // Occupancy once this edge's pop and in-flight push have settled; a new request
    // may only go out if its word is guaranteed a slot one edge later.
    assign occ_after = {1'b0, fifo_cnt}
                     + {{(PTR_W+1){1'b0}}, req_vld_p1}
                     - {{(PTR_W+1){1'b0}}, pop};

    assign issued_nxt  = issued_cnt + {{ADDR_LEN{1'b0}}, 1'b1};
    assign launch      = (state == S_READ) && !abort
                      && (issued_cnt != total_cnt) && (occ_after < FIFO_FULL);
    assign last_launch = launch && (issued_nxt == total_cnt);
    assign drained     = (fifo_cnt == {{PTR_W{1'b0}}, pop}) && !req_vld_p1;

    always_ff @(posedge rd_clk) begin
        if (rst || cancel) begin
            state        <= S_IDLE;
            sram_rd_en_n <= 1'b1;
            sram_rd_addr <= '0;
            next_addr    <= '0;
            total_cnt    <= '0;
            issued_cnt   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
        end else begin
            sram_rd_en_n <= !launch;
            if (launch) begin
                sram_rd_addr <= next_addr;
                next_addr    <= next_addr + {{(ADDR_LEN-1){1'b0}}, 1'b1};
                issued_cnt   <= issued_nxt;
            end

            if (req_vld_p1) begin
                wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            fifo_cnt <= fifo_cnt + {{PTR_W{1'b0}}, req_vld_p1} - {{PTR_W{1'b0}}, pop};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_addr  <= base_addr;
                        total_cnt  <= word_cnt;
                        issued_cnt <= '0;
                        state      <= (word_cnt == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (last_launch) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage carries data only; pointers and count decide what is live.
    always_ff @(posedge rd_clk) begin
        if (req_vld_p1) begin
            fifo_mem[wr_ptr] <= sram_data_i;
        end
    end

endmodule

// File: tb/tb_sram_readout.sv
// Directed bench for sram_readout: behavioural SRAM with one-cycle read latency and a
// stream consumer checking order, stall stability, done timing, abort and reset.
module tb_sram_readout;

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_cnt = '0;
    logic        busy;
    logic        done;
    logic [9:0]  sram_rd_addr;
    logic        sram_rd_en_n;
    logic [31:0] sram_data_i = '0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    sram_readout #(
        .DATA_LEN(32),
        .DEPTH(1024),
        .ADDR_LEN(10),
        .FIFO_DEPTH(4)
    ) dut (
        .rd_clk(rd_clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .word_cnt(word_cnt),
        .busy(busy),
        .done(done),
        .sram_rd_addr(sram_rd_addr),
        .sram_rd_en_n(sram_rd_en_n),
        .sram_data_i(sram_data_i),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [31:0] word(input int a);
        return 32'hD000_0000 | (a % 1024);
    endfunction

    // SRAM: data for the address launched at an edge appears shortly after it,
    // so it is stable at the following edge; otherwise the bus holds.
    always @(posedge rd_clk) begin
        #1;
        if (!sram_rd_en_n) sram_data_i = word(int'(sram_rd_addr));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input int base, input int cnt);
        base_addr = base[9:0];
        word_cnt  = cnt[10:0];
        start     = 1'b1;
        @(negedge rd_clk);
        start     = 1'b0;
    endtask

    task automatic consume(input string tag, input int base, input int n);
        int k = 0;
        int cyc = 0;
        m_ready = 1'b1;
        while (k < n && cyc < 100) begin
            if (m_valid) begin
                chk(tag, m_data, word(base + k));
                k++;
            end
            @(negedge rd_clk);
            cyc++;
        end
        chk({tag, "_count"}, k, n);
    endtask

    task automatic run_stream(input string tag, input int base, input int cnt, input int duty);
        int  xfer = 0;
        int  launched = 0;
        int  cyc = 0;
        bit  bad_addr = 0;
        bit  bad_hold = 0;
        bit  over = 0;
        bit  early_done = 0;
        bit  prev_stall = 0;
        logic [31:0] prev_data = '0;
        do_start(base, cnt);
        chk({tag, "_busy"}, busy, 1);
        while (xfer < cnt && cyc < cnt * 12 + 40) begin
            if (!sram_rd_en_n) begin
                if (sram_rd_addr !== 10'((base + launched) % 1024)) bad_addr = 1;
                launched++;
            end
            if (launched - xfer > 4) over = 1;
            if (done) early_done = 1;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) bad_hold = 1;
            m_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            if (m_valid && m_ready) begin
                chk({tag, "_data"}, m_data, word(base + xfer));
                xfer++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(negedge rd_clk);
            cyc++;
        end
        m_ready = 1'b0;
        chk({tag, "_xfers"}, xfer, cnt);
        chk({tag, "_launches"}, launched, cnt);
        chk({tag, "_addr_order"}, bad_addr, 0);
        chk({tag, "_fifo_bound"}, over, 0);
        chk({tag, "_stall_hold"}, bad_hold, 0);
        chk({tag, "_early_done"}, early_done, 0);
        if (duty >= 100) chk({tag, "_latency"}, cyc, cnt + 2);
        chk({tag, "_done_pulse"}, done, 1);
        @(negedge rd_clk);
        chk({tag, "_done_clear"}, done, 0);
        chk({tag, "_busy_clear"}, busy, 0);
        chk({tag, "_valid_clear"}, m_valid, 0);
    endtask

    initial begin
        bit quiet_bad;

        repeat (3) @(negedge rd_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_en_n", sram_rd_en_n, 1);
        chk("rst_addr", sram_rd_addr, 0);
        rst = 1'b0;
        @(negedge rd_clk);

        // Abort while idle is a no-op.
        abort = 1'b1;
        @(negedge rd_clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        run_stream("t1", 32'h010, 8, 100);
        run_stream("t2_wrap", 32'h3FE, 4, 100);
        run_stream("t3_bp", 32'h123, 16, 30);

        // Zero-length readout: done only, no SRAM access.
        do_start(32'h055, 0);
        chk("t4_done", done, 1);
        chk("t4_en_n", sram_rd_en_n, 1);
        chk("t4_valid", m_valid, 0);
        @(negedge rd_clk);
        chk("t4_done_clear", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_en_n2", sram_rd_en_n, 1);
        chk("t4_valid2", m_valid, 0);

        run_stream("t5_full", 32'h200, 1024, 100);

        // Abort after five words; a simultaneous start must be ignored.
        do_start(32'h100, 20);
        consume("t6_pre", 32'h100, 5);
        abort = 1'b1;
        start = 1'b1;
        base_addr = 10'h080;
        word_cnt = 11'd2;
        @(negedge rd_clk);
        abort = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        chk("t6_valid", m_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_en_n", sram_rd_en_n, 1);
        quiet_bad = 0;
        repeat (4) begin
            @(negedge rd_clk);
            if (m_valid || done || busy || !sram_rd_en_n) quiet_bad = 1;
        end
        chk("t6_quiet", quiet_bad, 0);
        run_stream("t6_post", 32'h040, 3, 100);

        // Reset in the middle of a readout.
        do_start(32'h300, 20);
        consume("t7_pre", 32'h300, 3);
        rst = 1'b1;
        @(negedge rd_clk);
        rst = 1'b0;
        m_ready = 1'b0;
        chk("t7_valid", m_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_en_n", sram_rd_en_n, 1);
        chk("t7_data", m_data, 0);
        chk("t7_addr", sram_rd_addr, 0);
        @(negedge rd_clk);
        run_stream("t7_post", 32'h3FF, 3, 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
